// File: rtl/bootstrap_loader.sv
// bootstrap_loader: packs an SPI byte stream into words, queues them in a FIFO and writes them to SRAM.
// Define BOOTSTRAP_CHECKSUM_EN to expect a trailing checksum word verified in the CHECK state.
module bootstrap_loader #(
  parameter int MEM_DATA_WIDTH    = 16,
  parameter int MEM_ADDRESS_WIDTH = 22,
  parameter int FIFO_DEPTH_LOG2   = 4,
  parameter int TIMEOUT_WIDTH     = 16
) (
  input  logic                         master_clk_i,
  input  logic                         master_rst_i,
  input  logic                         boot_start_i,
  input  logic [MEM_ADDRESS_WIDTH-1:0] boot_base_addr_i,
  input  logic [MEM_ADDRESS_WIDTH-1:0] boot_len_i,
  input  logic [TIMEOUT_WIDTH-1:0]     timeout_cycles_i,
  input  logic [7:0]                   spi_byte_i,
  input  logic                         spi_byte_valid_i,
  output logic                         spi_byte_ready_o,
  input  logic                         micro_req_i,
  input  logic [MEM_ADDRESS_WIDTH-1:0] micro_address_i,
  input  logic [MEM_DATA_WIDTH-1:0]    micro_datain_i,
  output logic                         micro_ack_o,
  output logic                         sram_req_o,
  output logic [MEM_ADDRESS_WIDTH-1:0] sram_address_o,
  output logic [MEM_DATA_WIDTH-1:0]    sram_datain_o,
  input  logic                         sram_ack_i,
  output logic                         boot_busy_o,
  output logic                         boot_done_o,
  output logic                         boot_error_o,
  output logic [1:0]                   boot_error_code_o,
  output logic [FIFO_DEPTH_LOG2:0]     fifo_level_o
);

  // state | meaning
  // IDLE  | nothing loaded since reset; micro owns SRAM
  // LOAD  | accepting bytes and writing words
  // DRAIN | all data words packed; flushing FIFO to SRAM
  // CHECK | comparing running sum against checksum word
  // DONE  | load complete; micro owns SRAM
  // ERROR | timeout or checksum failure; micro owns SRAM
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam int BPW   = MEM_DATA_WIDTH / 8;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LVL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  logic [2:0]                   state_q, state_d;
  logic [MEM_ADDRESS_WIDTH-1:0] wr_addr_q, len_q, pushed_q, written_q;
  logic [TIMEOUT_WIDTH-1:0]     tmo_q, wd_q;
  logic [1:0]                   err_code_q;
  logic [BCW-1:0]               byte_cnt_q;
  logic [MEM_DATA_WIDTH-1:0]    pack_q, word_d;
  logic [MEM_DATA_WIDTH-1:0]    fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, wr_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]     level_q;
`ifdef BOOTSTRAP_CHECKSUM_EN
  logic [MEM_DATA_WIDTH-1:0]    sum_q, cks_q;
  logic                         cks_got_q;
`endif

  logic idle_like, loading, start_ok, fifo_full, fifo_empty, want_data;
  logic byte_ready, byte_acc, word_done, push, pop, wr_req, wd_fire;

  assign idle_like  = state_q inside {ST_IDLE, ST_DONE, ST_ERROR};
  assign loading    = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign start_ok   = boot_start_i && !micro_req_i && idle_like;
  assign fifo_full  = (level_q == FULL_LVL);
  assign fifo_empty = (level_q == '0);
  assign want_data  = (pushed_q < len_q);
`ifdef BOOTSTRAP_CHECKSUM_EN
  // The checksum word bypasses the FIFO, so a full FIFO does not block it.
  assign byte_ready = (state_q == ST_LOAD) && (want_data ? !fifo_full : !cks_got_q);
`else
  assign byte_ready = (state_q == ST_LOAD) && want_data && !fifo_full;
`endif
  assign byte_acc   = byte_ready && spi_byte_valid_i;
  assign word_done  = byte_acc && (byte_cnt_q == BCW'(BPW - 1));
  assign push       = word_done && want_data;
  assign wr_req     = loading && !fifo_empty;
  assign pop        = wr_req && sram_ack_i;
  assign wd_fire    = loading && (tmo_q != '0) && (wd_q == '0) && !byte_acc && !sram_ack_i;

  always_comb begin
    word_d = pack_q;
    word_d[byte_cnt_q*8 +: 8] = spi_byte_i;
  end

  assign spi_byte_ready_o  = byte_ready;
  assign boot_busy_o       = loading || (state_q == ST_CHECK);
  assign boot_done_o       = (state_q == ST_DONE);
  assign boot_error_o      = (state_q == ST_ERROR);
  assign boot_error_code_o = err_code_q;
  assign fifo_level_o      = level_q;
  assign micro_ack_o       = idle_like && sram_ack_i;
  assign sram_req_o        = idle_like ? micro_req_i     : wr_req;
  assign sram_address_o    = idle_like ? micro_address_i : wr_addr_q;
  assign sram_datain_o     = idle_like ? micro_datain_i  : fifo_mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) state_d = (boot_len_i == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (wd_fire) state_d = ST_ERROR;
`ifdef BOOTSTRAP_CHECKSUM_EN
        else if (!want_data && cks_got_q) state_d = ST_DRAIN;
`else
        else if (!want_data) state_d = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        if (wd_fire) state_d = ST_ERROR;
`ifdef BOOTSTRAP_CHECKSUM_EN
        else if (written_q == len_q) state_d = ST_CHECK;
`else
        else if (written_q == len_q) state_d = ST_DONE;
`endif
      end
`ifdef BOOTSTRAP_CHECKSUM_EN
      ST_CHECK: state_d = (sum_q == cks_q) ? ST_DONE : ST_ERROR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= word_d;
  end

  always_ff @(posedge master_clk_i or negedge master_rst_i) begin
    if (!master_rst_i) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      len_q      <= '0;
      pushed_q   <= '0;
      written_q  <= '0;
      tmo_q      <= '0;
      wd_q       <= '0;
      err_code_q <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
`ifdef BOOTSTRAP_CHECKSUM_EN
      sum_q      <= '0;
      cks_q      <= '0;
      cks_got_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        wr_addr_q  <= boot_base_addr_i;
        len_q      <= boot_len_i;
        tmo_q      <= timeout_cycles_i;
        wd_q       <= timeout_cycles_i;
        pushed_q   <= '0;
        written_q  <= '0;
        err_code_q <= '0;
        byte_cnt_q <= '0;
        pack_q     <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        level_q    <= '0;
`ifdef BOOTSTRAP_CHECKSUM_EN
        sum_q      <= '0;
        cks_got_q  <= 1'b0;
`endif
      end else begin
        if (byte_acc) begin
          byte_cnt_q <= word_done ? '0 : byte_cnt_q + 1'b1;
          pack_q     <= word_d;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          pushed_q <= pushed_q + 1'b1;
`ifdef BOOTSTRAP_CHECKSUM_EN
          sum_q    <= sum_q + word_d;
`endif
        end
`ifdef BOOTSTRAP_CHECKSUM_EN
        if (word_done && !want_data) begin
          cks_q     <= word_d;
          cks_got_q <= 1'b1;
        end
        if ((state_q == ST_CHECK) && (sum_q != cks_q)) err_code_q <= 2'b10;
`endif
        if (pop) begin
          rd_ptr_q  <= rd_ptr_q + 1'b1;
          wr_addr_q <= wr_addr_q + 1'b1;
          written_q <= written_q + 1'b1;
        end
        if (push != pop) level_q <= push ? level_q + 1'b1 : level_q - 1'b1;
        if (loading) wd_q <= (byte_acc || sram_ack_i) ? tmo_q : wd_q - 1'b1;
        if (wd_fire) err_code_q <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_bootstrap_loader.sv
// Directed bench for bootstrap_loader: basic load, FIFO full, address wrap, watchdog, reset mid-drain.
// Checksum cases are compiled in when BOOTSTRAP_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_bootstrap_loader;
  localparam int MDW = 16;
  localparam int MAW = 22;
  localparam int FDL = 4;
  localparam int TW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           boot_start;
  logic [MAW-1:0] boot_base, boot_len;
  logic [TW-1:0]  tmo;
  logic [7:0]     spi_byte;
  logic           spi_valid, spi_ready;
  logic           micro_req, micro_ack;
  logic [MAW-1:0] micro_addr;
  logic [MDW-1:0] micro_data;
  logic           sram_req, sram_ack;
  logic [MAW-1:0] sram_addr;
  logic [MDW-1:0] sram_data;
  logic           busy, done, err;
  logic [1:0]     err_code;
  logic [FDL:0]   level;

  bootstrap_loader #(.MEM_DATA_WIDTH(MDW), .MEM_ADDRESS_WIDTH(MAW),
                     .FIFO_DEPTH_LOG2(FDL), .TIMEOUT_WIDTH(TW)) dut (
    .master_clk_i(clk), .master_rst_i(rst_n),
    .boot_start_i(boot_start), .boot_base_addr_i(boot_base), .boot_len_i(boot_len),
    .timeout_cycles_i(tmo), .spi_byte_i(spi_byte), .spi_byte_valid_i(spi_valid),
    .spi_byte_ready_o(spi_ready), .micro_req_i(micro_req), .micro_address_i(micro_addr),
    .micro_datain_i(micro_data), .micro_ack_o(micro_ack), .sram_req_o(sram_req),
    .sram_address_o(sram_addr), .sram_datain_o(sram_data), .sram_ack_i(sram_ack),
    .boot_busy_o(busy), .boot_done_o(done), .boot_error_o(err),
    .boot_error_code_o(err_code), .fifo_level_o(level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM model: acks a held request after ack_dly sampled cycles and logs the write.
  bit             ack_en = 1'b0;
  int             ack_dly = 1;
  int             ack_cnt = 0;
  logic [MAW-1:0] log_addr[$];
  logic [MDW-1:0] log_data[$];

  initial begin
    sram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sram_ack) sram_ack = 1'b0;
      else if (ack_en && sram_req) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          log_addr.push_back(sram_addr);
          log_data.push_back(sram_data);
          sram_ack = 1'b1;
          ack_cnt  = 0;
        end
      end else ack_cnt = 0;
    end
  end

  logic [7:0]     bq[$];
  logic [MDW-1:0] run_sum;

  task automatic add_word(input logic [MDW-1:0] w);
    bq.push_back(w[7:0]);
    bq.push_back(w[15:8]);
    run_sum = run_sum + w;
  endtask

  task automatic add_cks();
`ifdef BOOTSTRAP_CHECKSUM_EN
    logic [MDW-1:0] s;
    s = run_sum;
    bq.push_back(s[7:0]);
    bq.push_back(s[15:8]);
`endif
  endtask

  task automatic send_n(input int n, input string tag);
    for (int k = 0; k < n && bq.size() > 0; k++) begin
      int waited;
      waited    = 0;
      spi_byte  = bq.pop_front();
      spi_valid = 1'b1;
      while (!spi_ready && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      if (!spi_ready) begin
        check({tag, "_byte_ready"}, spi_ready, 1);
        break;
      end
      @(negedge clk);
    end
    spi_valid = 1'b0;
  endtask

  task automatic start(input logic [MAW-1:0] base, input logic [MAW-1:0] len, input logic [TW-1:0] t);
    bq.delete();
    log_addr.delete();
    log_data.delete();
    run_sum    = '0;
    boot_base  = base;
    boot_len   = len;
    tmo        = t;
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !(done || err); i++) @(negedge clk);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [MAW-1:0] a, input logic [MDW-1:0] d);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, log_addr[idx], a);
      check({tag, "_data"}, log_data[idx], d);
    end else check({tag, "_missing"}, log_addr.size(), idx + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, elapsed %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    boot_start = 1'b0;
    boot_base  = '0;
    boot_len   = '0;
    tmo        = '0;
    spi_byte   = '0;
    spi_valid  = 1'b0;
    micro_req  = 1'b0;
    micro_addr = 22'h2AAAA;
    micro_data = 16'h5A5A;
    run_sum    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", err, 0);
    check("rst_code", err_code, 0);
    check("rst_level", level, 0);
    check("rst_ready", spi_ready, 0);
    check("rst_req", sram_req, 0);
    check("rst_addr_mux", sram_addr, 22'h2AAAA);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load, two-cycle ack
    ack_en = 1'b1; ack_dly = 2;
    start(22'h000100, 22'd3, 16'd500);
    check("basic_busy", busy, 1);
    add_word(16'h2211); add_word(16'h4433); add_word(16'h6655); add_cks();
    send_n(bq.size(), "basic");
    wait_end(300);
    check("basic_done", done, 1);
    check_log("basic_w0", 0, 22'h000100, 16'h2211);
    check_log("basic_w1", 1, 22'h000101, 16'h4433);
    check_log("basic_w2", 2, 22'h000102, 16'h6655);
    repeat (5) @(negedge clk);
    check("basic_no_req", sram_req, 0);
    check("basic_nwrites", log_addr.size(), 3);
    micro_req = 1'b1; boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0; micro_req = 1'b0;
    check("start_blocked_done", done, 1);
    check("start_blocked_busy", busy, 0);
    repeat (3) @(negedge clk);

    // FIFO fills with SRAM stalled, then drains in order
    ack_en = 1'b0; ack_dly = 1;
    start(22'h000200, 22'd20, 16'd0);
    for (int i = 0; i < 20; i++) add_word({8'(2 * i + 1), 8'(2 * i)});
    add_cks();
    send_n(32, "full");
    check("full_level", level, 16);
    check("full_ready", spi_ready, 0);
    spi_byte = bq[0]; spi_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("full_level_hold", level, 16);
    check("full_ready_hold", spi_ready, 0);
    spi_valid = 1'b0;
    ack_en = 1'b1;
    send_n(bq.size(), "full_rest");
    wait_end(500);
    check("full_done", done, 1);
    check("full_nwrites", log_addr.size(), 20);
    for (int i = 0; i < 20; i++)
      check_log("full_w", i, 22'h000200 + 22'(i), {8'(2 * i + 1), 8'(2 * i)});

    // Address wraps past the top of the SRAM
    ack_dly = 1;
    start(22'h3FFFFF, 22'd2, 16'd200);
    add_word(16'h1234); add_word(16'hABCD); add_cks();
    send_n(bq.size(), "wrap");
    wait_end(200);
    check("wrap_done", done, 1);
    check_log("wrap_w0", 0, 22'h3FFFFF, 16'h1234);
    check_log("wrap_w1", 1, 22'h000000, 16'hABCD);

    // Watchdog: stream stalls after two of four words
    ack_dly = 2;
    start(22'h000300, 22'd4, 16'd100);
    add_word(16'hA1B2); add_word(16'hC3D4);
    send_n(4, "wd");
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (log_addr.size() >= 2) break;
    end
    check("wd_two_writes", log_addr.size(), 2);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wd_not_early", (n - 1) >= 100, 1);
    check("wd_not_late", (n - 1) <= 101, 1);
    check("wd_error", err, 1);
    check("wd_code", err_code, 2'b01);
    check("wd_req_low", sram_req, 0);
    micro_req = 1'b1; micro_addr = 22'h001234; micro_data = 16'hBEEF;
    #1;
    check("micro_req_pass", sram_req, 1);
    check("micro_addr_pass", sram_addr, 22'h001234);
    check("micro_data_pass", sram_data, 16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (micro_ack) break;
    end
    check("micro_ack", micro_ack, 1);
    @(negedge clk);
    micro_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while five words sit in the FIFO
    ack_en = 1'b0;
    start(22'h000400, 22'd5, 16'd0);
    for (int i = 0; i < 5; i++) add_word(16'h1000 + 16'(i));
    send_n(10, "rst");
    @(negedge clk);
    check("rst_mid_level", level, 5);
    check("rst_mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_level", level, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_req", sram_req, 0);
    check("rst_async_ready", spi_ready, 0);
    check("rst_async_done", done | err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_en = 1'b1; ack_dly = 1;
    start(22'h000050, 22'd1, 16'd50);
    add_word(16'h0C0D); add_cks();
    send_n(bq.size(), "post_rst");
    wait_end(200);
    check("post_rst_done", done, 1);
    check("post_rst_nwrites", log_addr.size(), 1);
    check_log("post_rst_w0", 0, 22'h000050, 16'h0C0D);

`ifdef BOOTSTRAP_CHECKSUM_EN
    start(22'h000600, 22'd2, 16'd200);
    add_word(16'h0001); add_word(16'h0002); add_cks();
    send_n(bq.size(), "cks_ok");
    wait_end(200);
    check("cks_ok_done", done, 1);
    check("cks_ok_code", err_code, 0);
    check_log("cks_ok_w0", 0, 22'h000600, 16'h0001);
    check_log("cks_ok_w1", 1, 22'h000601, 16'h0002);
    start(22'h000700, 22'd2, 16'd200);
    add_word(16'h0001); add_word(16'h0002);
    bq.push_back(8'h04); bq.push_back(8'h00);
    send_n(bq.size(), "cks_bad");
    wait_end(200);
    check("cks_bad_error", err, 1);
    check("cks_bad_code", err_code, 2'b10);
    check_log("cks_bad_w0", 0, 22'h000700, 16'h0001);
    check_log("cks_bad_w1", 1, 22'h000701, 16'h0002);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bootstrap_loader.md
Name: bootstrap_loader

Overview:
- Parametrised successor to the SPI-to-SRAM boot path.
- Accepts a byte stream from the SPI master and packs bytes into MEM_DATA_WIDTH words.
- Buffers the words in an internal circular FIFO of configurable depth and writes them to SRAM with a req/ack handshake, starting at a programmable base address for a programmable word count.
- Owns the SRAM port while loading; hands it to the microcontroller port when idle, done or in error. Adds a progress watchdog and error codes.

Parameters:
- MEM_DATA_WIDTH, 16: SRAM word width; must be a multiple of 8.
- MEM_ADDRESS_WIDTH, 22: SRAM address width; also the width of the length field.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2**FIFO_DEPTH_LOG2 words.
- TIMEOUT_WIDTH, 16: width of the watchdog counter.

Ports:
- master_clk_i  in  1  single clock.
- master_rst_i  in  1  asynchronous, active-low reset.
- boot_start_i  in  1  one-cycle start pulse.
- boot_base_addr_i  in  MEM_ADDRESS_WIDTH  first SRAM word address; sampled at start.
- boot_len_i  in  MEM_ADDRESS_WIDTH  number of data words; sampled at start.
- timeout_cycles_i  in  TIMEOUT_WIDTH  watchdog limit; sampled at start.
- spi_byte_i  in  8  byte from SPI.
- spi_byte_valid_i  in  1  byte valid.
- spi_byte_ready_o  out  1  byte accepted when valid and ready are both high.
- micro_req_i  in  1  micro SRAM write request.
- micro_address_i  in  MEM_ADDRESS_WIDTH  micro write address.
- micro_datain_i  in  MEM_DATA_WIDTH  micro write data.
- micro_ack_o  out  1  ack returned to micro.
- sram_req_o  out  1  SRAM write request.
- sram_address_o  out  MEM_ADDRESS_WIDTH  SRAM address.
- sram_datain_o  out  MEM_DATA_WIDTH  SRAM write data.
- sram_ack_i  in  1  SRAM write complete.
- boot_busy_o  out  1  high in LOAD, DRAIN, CHECK.
- boot_done_o  out  1  high in DONE.
- boot_error_o  out  1  high in ERROR.
- boot_error_code_o  out  2  00 none, 01 timeout, 10 checksum.
- fifo_level_o  out  FIFO_DEPTH_LOG2+1  words currently in the FIFO.

Behaviour:
- Reset (master_rst_i low, asynchronous):
  - state = IDLE; FIFO, packer and all counters cleared.
  - Registered outputs are 0: spi_byte_ready_o, sram_req_o, micro_ack_o, boot_busy_o, boot_done_o, boot_error_o, boot_error_code_o, fifo_level_o.
  - sram_address_o and sram_datain_o follow the micro mux while state is IDLE.
  - Reset may be applied at any point, including mid-transfer; the next start begins clean.
- States: IDLE, LOAD, DRAIN, CHECK, DONE, ERROR.
- Start handling:
  - boot_start_i is accepted only in IDLE, DONE or ERROR, and only with micro_req_i low; otherwise it is ignored.
  - On acceptance: base, length and timeout are latched; FIFO and packer are flushed; error code is cleared.
  - Next state is LOAD, or DONE the following cycle if boot_len_i = 0.
- Packer:
  - BPW = MEM_DATA_WIDTH/8 bytes per word, little-endian: the first byte goes to bits [7:0].
  - On the BPW-th accepted byte, the word is pushed into the FIFO in that same cycle.
  - spi_byte_ready_o = (state == LOAD) && FIFO not full && words_pushed < boot_len.
- LOAD → DRAIN when words_pushed reaches the latched length.
- Writer:
  - In LOAD and DRAIN, when the FIFO is not empty: sram_req_o = 1, with sram_address_o = write pointer and sram_datain_o = FIFO head.
  - Request, address and data are held stable until sram_ack_i.
  - On the ack cycle: pop the FIFO, increment the address modulo 2**MEM_ADDRESS_WIDTH (wraps to 0), increment words_written.
  - A new request may be issued the cycle after the ack.
- FIFO boundaries:
  - Push while full cannot occur, because ready is low.
  - A simultaneous push and pop leaves fifo_level_o unchanged.
  - Read and write pointers wrap modulo the depth.
- DRAIN → CHECK (macro defined) or DONE when words_written = length.
- Watchdog:
  - In LOAD/DRAIN, the counter resets on any accepted byte or any sram_ack_i, and otherwise increments.
  - When it equals timeout_cycles_i: go to ERROR, code 01, drop sram_req_o on the same edge.
  - A timeout of 0 disables the watchdog.
- Micro mux:
  - In IDLE/DONE/ERROR: sram_req_o, sram_address_o and sram_datain_o come from the micro_* inputs, and micro_ack_o = sram_ack_i.
  - In busy states: micro_ack_o = 0 and micro requests stall.
- DONE and ERROR are held until the next accepted start or reset.

Optional Feature:
- Macro: BOOTSTRAP_CHECKSUM_EN.
- Defined:
  - The stream carries one extra word after the length words. It is packed like the others but captured in a checksum register, not the FIFO.
  - A running sum of all data words modulo 2**MEM_DATA_WIDTH is kept as they are pushed.
  - CHECK (one cycle) compares the sum with the checksum word: equal → DONE; unequal → ERROR, code 10.
  - spi_byte_ready_o stays high until the checksum word is complete.
- Undefined: no extra word, no CHECK state; DRAIN goes directly to DONE; code 10 is never produced.

Test Plan:
- Basic load: MDW=16, base 0x000100, len 3, bytes 11 22 33 44 55 66, ack after 2 cycles → writes 0x2211@0x100, 0x4433@0x101, 0x6655@0x102; boot_done_o=1; no further sram_req_o.
- FIFO full: FIFO_DEPTH_LOG2=4, sram_ack_i held low, 40 bytes offered → fifo_level_o=16, spi_byte_ready_o=0. Release ack → all 20 words written in order, done.
- Address wrap: base 0x3FFFFF, len 2 → addresses 0x3FFFFF then 0x000000.
- Watchdog: timeout 100, len 4, stop bytes after word 2 is written → after 100 idle cycles boot_error_o=1, code 01, sram_req_o=0. Micro write then passes through with ack.
- Reset mid-DRAIN with 5 words queued → all outputs 0 immediately, fifo_level_o=0. A new start with len 1 completes normally.
- BOOTSTRAP_CHECKSUM_EN: words 0x0001, 0x0002 with checksum 0x0003 → DONE. With checksum 0x0004 → ERROR, code 10. Both data words are written to SRAM in each case.
